syn_av_mm_arb: RTL and testbench
================================

# syn_av_mm_arb

Round-robin arbiter that shares one Avalon-MM slave port (read/write/addr/write-data out, read-data/read-data-valid in, no slave waitrequest) among NUM_M masters. Each master gets a waitrequest-style stall, and read responses are routed back to the issuing master through an in-order tag FIFO. It sits between the synesthesia control masters and a shared register/memory slave.

## Interface
- ADDR_W, 12, address width
- DATA_W, 16, data width
- NUM_M, 2, number of masters (2..4)
- MAX_PEND, 4, max outstanding reads (power of 2, ≥2)
- av_clk  in  1  clock; all logic on posedge
- av_rst  in  1  asynchronous, active-low reset
- m_read  in  NUM_M  per-master read request
- m_write  in  NUM_M  per-master write request
- m_addr  in  NUM_M*ADDR_W  master i address at [i*ADDR_W +: ADDR_W]
- m_write_data  in  NUM_M*DATA_W  master i write data, same packing
- m_wait  out  NUM_M  1 = request not accepted this cycle, hold it
- m_read_data  out  DATA_W  returned read data, common to all masters
- m_rd_data_valid  out  NUM_M  one-hot, 1 = m_read_data belongs to master i
- av_read  out  1  slave read strobe
- av_write  out  1  slave write strobe
- av_addr  out  ADDR_W  slave address
- av_write_data  out  DATA_W  slave write data
- av_read_data  in  DATA_W  slave read data
- av_rd_data_valid  in  1  slave read data valid
- pend_cnt  out  clog2(MAX_PEND)+1  outstanding reads
- err_orphan  out  1  sticky; set when read data returns with nothing pending

## Operation
- Request i = m_read[i] | m_write[i]. If both are set, the request is a read and the write is ignored.
- Eligible i: request set, and if it is a read, pend_cnt < MAX_PEND. Writes are always eligible.
- Grant: at most one per cycle. Eligible masters are searched round-robin starting at last_grant+1 mod NUM_M. last_grant resets to NUM_M-1, so master 0 wins first.
- Accept: a granted request is accepted that cycle. last_grant updates to i; m_wait[i]=0.
- m_wait[i] = request[i] & ~grant[i], combinational. Idle masters see m_wait=0.
- An accepted command is registered onto av_* for exactly one cycle (av_read or av_write pulse, plus addr/data). When no command is accepted, av_read=av_write=0 and av_addr/av_write_data hold their last values.
- Tag FIFO, MAX_PEND deep, in order:
  - Push granted master id on a read accept.
  - Pop on av_rd_data_valid.
  - Push and pop in the same cycle leave pend_cnt unchanged.
- Response: on av_rd_data_valid with FIFO non-empty, register m_read_data ← av_read_data and m_rd_data_valid ← onehot(head id) for one cycle.
- Orphan: av_rd_data_valid with FIFO empty (and no same-cycle push) does not pop, drives no valid, and sets err_orphan. err_orphan clears only on reset.
- Pending limit: a master requesting a read while pend_cnt == MAX_PEND stays stalled. Other masters' writes can still be granted in that cycle.

## Timing
- Reset (av_rst=0) values:
  - av_read=av_write=0; av_addr=0; av_write_data=0.
  - m_read_data=0; m_rd_data_valid=0; pend_cnt=0; err_orphan=0.
  - FIFO empty; last_grant=NUM_M-1.
  - m_wait=request while in reset (nothing accepted).
- Reset mid-operation flushes the FIFO. Read data arriving after reset release is an orphan.
- Command latency: accept in cycle N → av_* strobe in cycle N+1.
- Back-to-back: a new accept every cycle is possible, giving a continuous av_* strobe stream.
- Read return: av_rd_data_valid in cycle M → m_rd_data_valid in cycle M+1.
- The slave may return valid as early as the cycle after the av_read strobe.
- pend_cnt updates on the clock edge after the accept/return event.
- A read accepted in cycle N counts from N+1, so a read with pend_cnt == MAX_PEND-1 in cycle N blocks a further read in N+1 unless a pop occurs in N.

## Test plan
- Single master 0 write addr 0x010 data 0xBEEF:
  - m_wait[0]=0 in the request cycle.
  - Next cycle: av_write=1, av_addr=0x010, av_write_data=0xBEEF, for one cycle only.
- Both masters request writes continuously for 6 cycles:
  - Grants alternate 0,1,0,1,0,1.
  - The loser sees m_wait=1 each cycle.
  - av_write is high on 6 consecutive cycles.
- Master 0 reads 0x001, master 1 reads 0x002; slave returns 0x1111 then 0x2222 with 3-cycle latency:
  - m_rd_data_valid=01 with 0x1111, then 10 with 0x2222, each one cycle after av_rd_data_valid.
- Master 0 issues 5 reads with no slave response (MAX_PEND=4):
  - 4 accepted; pend_cnt=4; 5th stalled.
  - Master 1's write is still accepted while master 0 is stalled.
  - One return → pend_cnt=3, then the 5th read is accepted.
- Same-cycle read accept and av_rd_data_valid at pend_cnt=2 → pend_cnt stays 2 and the correct master gets the data.
- av_rd_data_valid with FIFO empty → no m_rd_data_valid, err_orphan=1. Assert av_rst low mid-traffic → all outputs return to reset values, pend_cnt=0, err_orphan=0.

Source files
------------

// File: rtl/syn_av_mm_arb.sv
// Round-robin arbiter sharing one Avalon-MM slave among NUM_M masters.
// Read responses are steered back to the issuing master through an in-order tag FIFO.

module syn_av_mm_arb_lane (
  input  logic rd,
  input  logic wr,
  input  logic full,
  output logic req,
  output logic is_rd,
  output logic elig
);
  // A read wins over a simultaneous write. A read is held off while the tag FIFO is full.
  assign req   = rd | wr;
  assign is_rd = rd;
  assign elig  = wr & ~rd | rd & ~full;
endmodule

module syn_av_mm_arb #(
  parameter  int ADDR_W   = 12,
  parameter  int DATA_W   = 16,
  parameter  int NUM_M    = 2,
  parameter  int MAX_PEND = 4,
  localparam int PEND_W   = $clog2(MAX_PEND) + 1
) (
  input  logic                      av_clk,
  input  logic                      av_rst,
  input  logic [NUM_M-1:0]          m_read,
  input  logic [NUM_M-1:0]          m_write,
  input  logic [NUM_M*ADDR_W-1:0]   m_addr,
  input  logic [NUM_M*DATA_W-1:0]   m_write_data,
  output logic [NUM_M-1:0]          m_wait,
  output logic [DATA_W-1:0]         m_read_data,
  output logic [NUM_M-1:0]          m_rd_data_valid,
  output logic                      av_read,
  output logic                      av_write,
  output logic [ADDR_W-1:0]         av_addr,
  output logic [DATA_W-1:0]         av_write_data,
  input  logic [DATA_W-1:0]         av_read_data,
  input  logic                      av_rd_data_valid,
  output logic [PEND_W-1:0]         pend_cnt,
  output logic                      err_orphan
);
  localparam int ID_W  = $clog2(NUM_M);
  localparam int PTR_W = $clog2(MAX_PEND);

  logic [NUM_M-1:0] req, is_rd, elig, grant;
  logic [ID_W-1:0]  last_grant, gnt_id, head_id;
  logic             gnt_vld, full, empty;
  logic             push, wr_en, rd_en, rsp, orphan;

  logic [ID_W-1:0]  tag_mem [MAX_PEND];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  assign full  = (pend_cnt == PEND_W'(MAX_PEND));
  assign empty = (pend_cnt == '0);

  for (genvar i = 0; i < NUM_M; i++) begin : g_lane
    syn_av_mm_arb_lane u_lane (
      .rd   (m_read[i]),
      .wr   (m_write[i]),
      .full (full),
      .req  (req[i]),
      .is_rd(is_rd[i]),
      .elig (elig[i])
    );
  end

  // Search starts one past the last winner; nothing is granted while in reset.
  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    for (int k = 1; k <= NUM_M; k++) begin
      idx = (int'(last_grant) + k) % NUM_M;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
    if (!av_rst) gnt_vld = 1'b0;
    if (gnt_vld) grant[gnt_id] = 1'b1;
  end

  assign m_wait = req & ~grant;
  assign push   = gnt_vld & is_rd[gnt_id];

  // Data landing on an empty FIFO in the same cycle as a read push goes straight to that master.
  assign rd_en   = av_rd_data_valid & ~empty;
  assign rsp     = av_rd_data_valid & (~empty | push);
  assign wr_en   = push & ~(av_rd_data_valid & empty);
  assign orphan  = av_rd_data_valid & empty & ~push;
  assign head_id = empty ? gnt_id : tag_mem[rd_ptr];

  always_ff @(posedge av_clk) begin
    if (wr_en) tag_mem[wr_ptr] <= gnt_id;
  end

  always_ff @(posedge av_clk or negedge av_rst) begin
    if (!av_rst) begin
      av_read         <= 1'b0;
      av_write        <= 1'b0;
      av_addr         <= '0;
      av_write_data   <= '0;
      last_grant      <= ID_W'(NUM_M - 1);
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      pend_cnt        <= '0;
      m_read_data     <= '0;
      m_rd_data_valid <= '0;
      err_orphan      <= 1'b0;
    end else begin
      av_read  <= push;
      av_write <= gnt_vld & ~is_rd[gnt_id];
      if (gnt_vld) begin
        av_addr       <= m_addr[gnt_id*ADDR_W +: ADDR_W];
        av_write_data <= m_write_data[gnt_id*DATA_W +: DATA_W];
        last_grant    <= gnt_id;
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   pend_cnt <= pend_cnt + 1'b1;
        2'b01:   pend_cnt <= pend_cnt - 1'b1;
        default: pend_cnt <= pend_cnt;
      endcase
      m_rd_data_valid <= rsp ? ({{(NUM_M-1){1'b0}}, 1'b1} << head_id) : '0;
      if (rsp) m_read_data <= av_read_data;
      if (orphan) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_syn_av_mm_arb.sv
// Directed and randomized checks of syn_av_mm_arb against a queue-based reference model.

module tb_syn_av_mm_arb;
  localparam int AW = 12, DW = 16, NM = 2, MP = 4, PW = $clog2(MP) + 1;

  logic              av_clk = 1'b0;
  logic              av_rst;
  logic [NM-1:0]     m_read, m_write, m_wait, m_rd_data_valid;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_write_data;
  logic [DW-1:0]     m_read_data, av_write_data, av_read_data;
  logic              av_read, av_write, av_rd_data_valid, err_orphan;
  logic [AW-1:0]     av_addr;
  logic [PW-1:0]     pend_cnt;

  always #5 av_clk = ~av_clk;

  syn_av_mm_arb #(.ADDR_W(AW), .DATA_W(DW), .NUM_M(NM), .MAX_PEND(MP)) dut (
    .av_clk(av_clk), .av_rst(av_rst),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_write_data(m_write_data),
    .m_wait(m_wait), .m_read_data(m_read_data), .m_rd_data_valid(m_rd_data_valid),
    .av_read(av_read), .av_write(av_write), .av_addr(av_addr), .av_write_data(av_write_data),
    .av_read_data(av_read_data), .av_rd_data_valid(av_rd_data_valid),
    .pend_cnt(pend_cnt), .err_orphan(err_orphan)
  );

  int checks = 0, errors = 0;

  // Reference model: queue of master ids awaiting data, last winner, sticky orphan.
  int            q[$];
  int            last;
  logic          e_rd, e_wr, e_orph;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;
  logic [NM-1:0] e_vld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of traffic: predict the grant, check m_wait, then check registered results.
  task automatic step(input logic rdv, input logic [DW-1:0] rdata, output int gnt);
    logic [NM-1:0] exp_wait;
    bit push;
    gnt = -1;
    av_rd_data_valid = rdv;
    av_read_data     = rdata;
    for (int k = 1; k <= NM; k++) begin
      int i;
      i = (last + k) % NM;
      if (gnt < 0 && (m_read[i] || m_write[i]) && (!m_read[i] || q.size() < MP)) gnt = i;
    end
    exp_wait = m_read | m_write;
    if (gnt >= 0) exp_wait[gnt] = 1'b0;
    @(negedge av_clk);
    chk("m_wait", 32'(m_wait), 32'(exp_wait));
    e_rd = 1'b0; e_wr = 1'b0; e_vld = '0; push = 0;
    if (gnt >= 0) begin
      last    = gnt;
      e_rd    = m_read[gnt];
      e_wr    = !m_read[gnt];
      e_addr  = m_addr[gnt*AW +: AW];
      e_wdata = m_write_data[gnt*DW +: DW];
      push    = m_read[gnt];
    end
    if (rdv) begin
      if (q.size() > 0) begin
        e_vld[q[0]] = 1'b1; e_rdata = rdata; void'(q.pop_front());
      end else if (push) begin
        e_vld[gnt] = 1'b1; e_rdata = rdata; push = 0;
      end else e_orph = 1'b1;
    end
    if (push) q.push_back(gnt);
    @(posedge av_clk); #1;
    av_rd_data_valid = 1'b0;
    chk("av_read", 32'(av_read), 32'(e_rd));
    chk("av_write", 32'(av_write), 32'(e_wr));
    chk("av_addr", 32'(av_addr), 32'(e_addr));
    chk("av_write_data", 32'(av_write_data), 32'(e_wdata));
    chk("m_rd_data_valid", 32'(m_rd_data_valid), 32'(e_vld));
    if (e_vld != '0) chk("m_read_data", 32'(m_read_data), 32'(e_rdata));
    chk("pend_cnt", 32'(pend_cnt), 32'(q.size()));
    chk("err_orphan", 32'(err_orphan), 32'(e_orph));
  endtask

  // Assert reset for one edge with whatever requests are present, then release.
  task automatic reset_dut();
    av_rst = 1'b0;
    av_rd_data_valid = 1'b0;
    #1;
    chk("rst_m_wait", 32'(m_wait), 32'(m_read | m_write));
    chk("rst_av_read", 32'(av_read), 32'd0);
    chk("rst_av_write", 32'(av_write), 32'd0);
    chk("rst_av_addr", 32'(av_addr), 32'd0);
    chk("rst_av_wdata", 32'(av_write_data), 32'd0);
    chk("rst_m_read_data", 32'(m_read_data), 32'd0);
    chk("rst_m_rdv", 32'(m_rd_data_valid), 32'd0);
    chk("rst_pend_cnt", 32'(pend_cnt), 32'd0);
    chk("rst_err_orphan", 32'(err_orphan), 32'd0);
    @(posedge av_clk); #1;
    chk("rst_hold_av_read", 32'(av_read | av_write), 32'd0);
    chk("rst_hold_m_wait", 32'(m_wait), 32'(m_read | m_write));
    q.delete();
    last = NM - 1; e_orph = 1'b0;
    e_addr = '0; e_wdata = '0;
    av_rst = 1'b1;
  endtask

  initial begin
    int g;
    av_rst = 1'b1;
    m_read = '0; m_write = '0; m_addr = '0; m_write_data = '0;
    av_read_data = '0; av_rd_data_valid = 1'b0;
    @(posedge av_clk); #1;
    m_write = 2'b01;
    reset_dut();
    m_write = '0;

    // Single write from master 0
    m_write = 2'b01;
    m_addr[0 +: AW] = 12'h010; m_write_data[0 +: DW] = 16'hBEEF;
    step(1'b0, '0, g);
    chk("w1_av_write", 32'(av_write), 32'd1);
    chk("w1_av_addr", 32'(av_addr), 32'h010);
    chk("w1_av_wdata", 32'(av_write_data), 32'hBEEF);
    m_write = '0;
    step(1'b0, '0, g);
    chk("w1_one_cycle", 32'(av_write), 32'd0);

    // Both masters write continuously: grants alternate from master 0
    reset_dut();
    m_addr = {12'h200, 12'h100}; m_write_data = {16'h2222, 16'h1111};
    m_write = 2'b11;
    for (int n = 0; n < 6; n++) begin
      step(1'b0, '0, g);
      chk("alt_av_write", 32'(av_write), 32'd1);
      chk("alt_av_addr", 32'(av_addr), (n % 2) ? 32'h200 : 32'h100);
    end
    m_write = '0;

    // Two reads routed back in order
    m_addr = {12'h002, 12'h001};
    m_read = 2'b11;
    for (int n = 0; n < 2; n++) begin
      step(1'b0, '0, g);
      if (g >= 0) m_read[g] = 1'b0;
    end
    step(1'b0, '0, g);
    step(1'b1, 16'h1111, g);
    chk("rd_route0_vld", 32'(m_rd_data_valid), 32'b01);
    chk("rd_route0_data", 32'(m_read_data), 32'h1111);
    step(1'b1, 16'h2222, g);
    chk("rd_route1_vld", 32'(m_rd_data_valid), 32'b10);
    chk("rd_route1_data", 32'(m_read_data), 32'h2222);

    // Pending limit: fifth read stalls, other master's write still goes
    m_read = 2'b01;
    for (int n = 0; n < 4; n++) begin
      m_addr[0 +: AW] = AW'(12'h030 + n);
      step(1'b0, '0, g);
    end
    chk("lim_pend4", 32'(pend_cnt), 32'd4);
    m_write = 2'b10;
    step(1'b0, '0, g);
    chk("lim_write_ok", 32'(av_write), 32'd1);
    m_write = '0;
    step(1'b1, 16'hA001, g);
    chk("lim_pend3", 32'(pend_cnt), 32'd3);
    chk("lim_still_blocked", 32'(av_read), 32'd0);
    step(1'b0, '0, g);
    chk("lim_fifth_rd", 32'(av_read), 32'd1);
    chk("lim_pend4b", 32'(pend_cnt), 32'd4);
    m_read = '0;
    for (int n = 0; n < 4; n++) step(1'b1, DW'(16'hA010 + n), g);
    chk("lim_drained", 32'(pend_cnt), 32'd0);

    // Simultaneous push and pop at pend_cnt=2
    m_read = 2'b01;
    step(1'b0, '0, g);
    step(1'b0, '0, g);
    m_read = 2'b10;
    step(1'b1, 16'hB000, g);
    chk("pp_pend2", 32'(pend_cnt), 32'd2);
    chk("pp_route", 32'(m_rd_data_valid), 32'b01);
    m_read = '0;
    step(1'b1, 16'hB001, g);
    step(1'b1, 16'hB002, g);
    chk("pp_last_route", 32'(m_rd_data_valid), 32'b10);
    chk("pp_last_data", 32'(m_read_data), 32'hB002);

    // Orphan return
    step(1'b1, 16'h5555, g);
    chk("orph_flag", 32'(err_orphan), 32'd1);
    chk("orph_no_vld", 32'(m_rd_data_valid), 32'd0);
    step(1'b0, '0, g);
    chk("orph_sticky", 32'(err_orphan), 32'd1);

    // Reset in the middle of read traffic flushes the FIFO
    m_read = 2'b11;
    step(1'b0, '0, g);
    reset_dut();
    m_read = '0;
    step(1'b1, 16'h7777, g);
    chk("post_rst_orphan", 32'(err_orphan), 32'd1);
    chk("post_rst_no_vld", 32'(m_rd_data_valid), 32'd0);

    // Randomized traffic
    reset_dut();
    for (int n = 0; n < 400; n++) begin
      logic rdv;
      m_read       = NM'($urandom);
      m_write      = NM'($urandom);
      m_addr       = (NM*AW)'($urandom);
      m_write_data = (NM*DW)'($urandom);
      rdv = (q.size() > 0) ? ($urandom_range(2) == 0) : ($urandom_range(40) == 0);
      step(rdv, DW'($urandom), g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
